// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter: turns switch release edges into events, serialises them round-robin
// onto one valid/ready port and keeps a per-switch LED toggle bit.
module switch_event_arbiter #(
  parameter int NUM_SW = 4,
  localparam int ID_W = $clog2(NUM_SW)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic              o_Event_Valid,
  output logic [ID_W-1:0]   o_Event_Id,
  input  logic              i_Event_Ready,
  output logic [NUM_SW-1:0] o_LED,
  output logic [NUM_SW-1:0] o_Overrun,
  input  logic              i_Clear_Overrun
);
  localparam int IW = ID_W + 1;
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_d;
  logic [NUM_SW-1:0] r_switch, rel, pending, load_mask, kept, ovr_set;
  logic [ID_W-1:0] pointer, start, win;
  logic hs, load;
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    logic [ID_W:0] s;
    s = {1'b0, a} + IW'(b);
    return ID_W'(s >= IW'(NUM_SW) ? s - IW'(NUM_SW) : s);
  endfunction
  assign rel = r_switch & ~i_Switch;
  assign o_Event_Valid = state == OFFER;
  // On a handshake the next winner is searched from the slot after the accepted id,
  // so back-to-back grants already honour the pointer that is about to be written.
  always_comb begin
    hs = (state == OFFER) & i_Event_Ready;
    start = hs ? wrap_add(o_Event_Id, 1) : pointer;
    win = '0;
    for (int i = NUM_SW - 1; i >= 0; i--)
      win = pending[wrap_add(start, i)] ? wrap_add(start, i) : win;
    load = (|pending) & ((state == IDLE) | hs);
    state_d = load ? OFFER : hs ? IDLE : state;
    load_mask = load ? NUM_SW'(1) << win : '0;
    kept = pending & ~load_mask;
    ovr_set = rel & kept;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      r_switch <= '0;
      pending <= '0;
      pointer <= '0;
      o_Event_Id <= '0;
      o_LED <= '0;
      o_Overrun <= '0;
    end else begin
      state <= state_d;
      r_switch <= i_Switch;
      pending <= kept | rel;
      if (load) o_Event_Id <= win;
      if (hs) begin
        o_LED[o_Event_Id] <= ~o_LED[o_Event_Id];
        pointer <= wrap_add(o_Event_Id, 1);
      end
      o_Overrun <= (i_Clear_Overrun ? '0 : o_Overrun) | ovr_set;
    end
  end
endmodule
